// File: rtl/requant_tile_sched.sv
// ============================================================================
// Module   : requant_tile_sched
// Brief    : Walks output channels in VLEN-wide groups, arbitrating the
//            requant parameter fetch and sequencing each group's compute.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module requant_tile_sched #(
  parameter int VLEN        = 16,
  parameter int REG_WIDTH   = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         cfg_per_channel,
  input  logic [REG_WIDTH-1:0]         n_ch,
  input  logic [REG_WIDTH-1:0]         n_rows,
  output logic                         init_cfg,
  input  logic                         load_quant_req,
  output logic                         load_quant_granted,
  input  logic                         quant_params_valid,
  input  logic                         bus_busy,
  input  logic                         out_valid,
  output logic                         tile_calc_start,
  output logic [REG_WIDTH-1:0]         tile_ch_base,
  output logic [$clog2(VLEN+1)-1:0]    tile_ch_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err
);

  localparam int c_CNT_W = $clog2(VLEN+1);
  localparam int c_WD_W  = $clog2(TIMEOUT_CYC+1);

  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_CFG        = 3'd1;
  localparam logic [2:0] c_WAIT_REQ   = 3'd2;
  localparam logic [2:0] c_GRANT      = 3'd3;
  localparam logic [2:0] c_WAIT_PARAM = 3'd4;
  localparam logic [2:0] c_COMPUTE    = 3'd5;
  localparam logic [2:0] c_NEXT       = 3'd6;

  localparam logic [REG_WIDTH:0]   c_VLEN_EXT = (REG_WIDTH+1)'(VLEN);
  localparam logic [REG_WIDTH-1:0] c_VLEN_REG = REG_WIDTH'(VLEN);
  localparam logic [c_WD_W-1:0]    c_WD_LAST  = c_WD_W'(TIMEOUT_CYC-1);

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic                 w_finish;
  logic                 w_timeout;

  logic                 r_per_ch;
  logic [REG_WIDTH-1:0] r_n_ch;
  logic [REG_WIDTH-1:0] r_n_rows;
  logic [REG_WIDTH-1:0] r_base;
  logic [REG_WIDTH-1:0] r_beat;
  logic [c_WD_W-1:0]    r_wd;
  logic                 r_done;
  logic                 r_tcs;
  logic                 r_terr;

  logic [REG_WIDTH-1:0] w_beat_inc;
  logic [REG_WIDTH:0]   w_base_ext;
  logic                 w_last;
  logic [REG_WIDTH-1:0] w_remain;
  logic                 w_waiting;
  logic                 w_next_waiting;
  logic                 w_wd_hit;
  logic                 w_enter_compute;

  assign w_beat_inc      = r_beat + REG_WIDTH'(1);
  // One extra bit keeps base+VLEN from wrapping near the top of the range.
  assign w_base_ext      = {1'b0, r_base} + c_VLEN_EXT;
  assign w_last          = (w_base_ext >= {1'b0, r_n_ch});
  assign w_remain        = r_n_ch - r_base;
  assign w_waiting       = (r_state == c_WAIT_REQ) || (r_state == c_GRANT) ||
                           (r_state == c_WAIT_PARAM);
  assign w_next_waiting  = (w_next == c_WAIT_REQ) || (w_next == c_GRANT) ||
                           (w_next == c_WAIT_PARAM);
  assign w_wd_hit        = w_waiting && (r_wd == c_WD_LAST);
  assign w_enter_compute = (w_next == c_COMPUTE) && (r_state != c_COMPUTE);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the watchdog overrides any handshake progress.
  always_comb begin
    w_next    = r_state;
    w_finish  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_next = c_CFG;
        end
      end
      c_CFG: begin
        if ((r_n_ch == '0) || (r_n_rows == '0)) begin
          w_next   = c_IDLE;
          w_finish = 1'b1;
        end else if (r_per_ch) begin
          w_next = c_WAIT_REQ;
        end else begin
          w_next = c_COMPUTE;
        end
      end
      c_WAIT_REQ: begin
        if (w_wd_hit) begin
          w_next    = c_IDLE;
          w_timeout = 1'b1;
        end else if (load_quant_req) begin
          w_next = c_GRANT;
        end
      end
      c_GRANT: begin
        if (w_wd_hit) begin
          w_next    = c_IDLE;
          w_timeout = 1'b1;
        end else if (load_quant_req && !bus_busy) begin
          w_next = c_WAIT_PARAM;
        end
      end
      c_WAIT_PARAM: begin
        if (w_wd_hit) begin
          w_next    = c_IDLE;
          w_timeout = 1'b1;
        end else if (quant_params_valid) begin
          w_next = c_COMPUTE;
        end
      end
      c_COMPUTE: begin
        if (out_valid && (w_beat_inc == r_n_rows)) begin
          w_next = c_NEXT;
        end
      end
      c_NEXT: begin
        if (w_last) begin
          w_next   = c_IDLE;
          w_finish = 1'b1;
        end else if (r_per_ch) begin
          w_next = c_WAIT_REQ;
        end else begin
          w_next = c_COMPUTE;
        end
      end
      default: begin
        w_next = c_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    init_cfg           = (r_state == c_CFG);
    busy               = (r_state != c_IDLE);
    load_quant_granted = (r_state == c_GRANT) && load_quant_req && !bus_busy &&
                         !w_wd_hit;
    tile_calc_start    = r_tcs;
    done               = r_done;
    timeout_err        = r_terr;
    tile_ch_base       = r_base;
    if (w_remain >= c_VLEN_REG) begin
      tile_ch_cnt = c_CNT_W'(VLEN);
    end else begin
      tile_ch_cnt = w_remain[c_CNT_W-1:0];
    end
  end

  // Job configuration, group pointer, counters and registered pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_per_ch <= 1'b0;
      r_n_ch   <= '0;
      r_n_rows <= '0;
      r_base   <= '0;
      r_beat   <= '0;
      r_wd     <= '0;
      r_done   <= 1'b0;
      r_tcs    <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      r_done <= w_finish || w_timeout;
      r_tcs  <= w_enter_compute;
      r_wd   <= (w_waiting && w_next_waiting) ? (r_wd + c_WD_W'(1)) : '0;

      if ((r_state == c_IDLE) && start) begin
        r_per_ch <= cfg_per_channel;
        r_n_ch   <= n_ch;
        r_n_rows <= n_rows;
        r_terr   <= 1'b0;
      end else if (w_timeout) begin
        r_terr <= 1'b1;
      end

      if ((r_state == c_IDLE) && start) begin
        r_base <= '0;
      end else if ((r_state == c_NEXT) && !w_last) begin
        r_base <= r_base + c_VLEN_REG;
      end

      if (w_enter_compute) begin
        r_beat <= '0;
      end else if ((r_state == c_COMPUTE) && out_valid) begin
        r_beat <= w_beat_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_requant_tile_sched.sv
// Bench for requant_tile_sched: scoreboard of grant / group-start / done
// events plus cycle-exact checks on job timing, bus contention and the watchdog.
`default_nettype none

module tb_requant_tile_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, start_wd;
  logic        cfg_per_channel;
  logic [31:0] n_ch, n_rows;
  logic        load_quant_req, quant_params_valid, bus_busy, out_valid;

  logic        init_cfg, load_quant_granted, tile_calc_start, busy, done, timeout_err;
  logic [31:0] tile_ch_base;
  logic [4:0]  tile_ch_cnt;

  logic        init_cfg_wd, grant_wd, tcs_wd, busy_wd, done_wd, timeout_err_wd;
  logic [31:0] base_wd;
  logic [4:0]  cnt_wd;

  always #5 clk = ~clk;

  requant_tile_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_per_channel(cfg_per_channel),
    .n_ch(n_ch), .n_rows(n_rows), .init_cfg(init_cfg),
    .load_quant_req(load_quant_req), .load_quant_granted(load_quant_granted),
    .quant_params_valid(quant_params_valid), .bus_busy(bus_busy),
    .out_valid(out_valid), .tile_calc_start(tile_calc_start),
    .tile_ch_base(tile_ch_base), .tile_ch_cnt(tile_ch_cnt),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  requant_tile_sched #(.TIMEOUT_CYC(8)) dut_wd (
    .clk(clk), .rstn(rstn), .start(start_wd), .cfg_per_channel(cfg_per_channel),
    .n_ch(n_ch), .n_rows(n_rows), .init_cfg(init_cfg_wd),
    .load_quant_req(load_quant_req), .load_quant_granted(grant_wd),
    .quant_params_valid(quant_params_valid), .bus_busy(bus_busy),
    .out_valid(out_valid), .tile_calc_start(tcs_wd),
    .tile_ch_base(base_wd), .tile_ch_cnt(cnt_wd),
    .busy(busy_wd), .done(done_wd), .timeout_err(timeout_err_wd)
  );

  typedef struct {
    int kind;  // 0 grant, 1 group start, 2 done
    int base;
    int cnt;
    int terr;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc, beats, cur_rows;
  bit  pend_tcs;
  int  tcs1_cyc, done_cyc, init_cyc, n_init, n_grant, n_tcs, n_done;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int base, input int cnt, input int terr);
    ev_t e;
    e.kind = kind; e.base = base; e.cnt = cnt; e.terr = terr;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int base, input int cnt, input int terr);
    ev_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_event", kind, -1);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", kind, e.kind);
      if (kind == 1) begin
        chk("sb_base", base, e.base);
        chk("sb_cnt", cnt, e.cnt);
      end
      if (kind == 2) chk("sb_terr", terr, e.terr);
    end
  endtask

  task automatic monitor();
    if (init_cfg) begin
      n_init++;
      if (init_cyc < 0) init_cyc = cyc;
    end
    if (load_quant_granted) begin
      n_grant++;
      sb_pop(0, 0, 0, 0);
    end
    if (tile_calc_start) begin
      n_tcs++;
      if (tcs1_cyc < 0) tcs1_cyc = cyc;
      pend_tcs = 1'b1;
      sb_pop(1, int'(tile_ch_base), int'(tile_ch_cnt), 0);
    end
    if (done) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc;
      sb_pop(2, 0, 0, int'(timeout_err));
    end
  endtask

  // Requant-unit model: streams n_rows beats after each group start.
  task automatic drive(input int mode);
    start    = (mode == 2) && (cyc == 3);
    bus_busy = (mode == 1) && (cyc < 8);
    if (pend_tcs) begin
      beats    = cur_rows;
      pend_tcs = 1'b0;
    end
    out_valid = (beats > 0);
    if (beats > 0) beats--;
  endtask

  // mode: 0 plain, 1 bus held busy cycles 3..7, 2 stray start during compute
  task automatic run_job(input bit per_ch, input int nch, input int nrows, input int mode);
    if (nch != 0 && nrows != 0) begin
      for (int b = 0; b < nch; b += 16) begin
        if (per_ch) push_ev(0, 0, 0, 0);
        push_ev(1, b, (nch - b < 16) ? nch - b : 16, 0);
      end
    end
    push_ev(2, 0, 0, 0);
    tcs1_cyc = -1; done_cyc = -1; init_cyc = -1;
    n_init = 0; n_grant = 0; n_tcs = 0; n_done = 0;
    beats = 0; pend_tcs = 1'b0; cur_rows = nrows;
    @(posedge clk); #1;
    cyc = 0;
    cfg_per_channel    = per_ch;
    n_ch               = nch;
    n_rows             = nrows;
    load_quant_req     = 1'b1;
    quant_params_valid = 1'b1;
    bus_busy           = (mode == 1);
    out_valid          = 1'b0;
    start              = 1'b1;
    for (int i = 0; i < 400 && done_cyc < 0; i++) begin
      @(negedge clk);
      monitor();
      if (mode == 1 && cyc >= 3 && cyc <= 9)
        chk("busy_grant_window", load_quant_granted, (cyc == 8));
      @(posedge clk); #1;
      cyc++;
      drive(mode);
    end
    chk("job_completed", (done_cyc >= 0), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      monitor();
      @(posedge clk); #1;
      cyc++;
      drive(0);
    end
    chk("init_cfg_cycle", init_cyc, 1);
    chk("init_cfg_width", n_init, 1);
    chk("done_count", n_done, 1);
    chk("sb_drained", sb.size(), 0);
    chk("idle_after_job", busy, 0);
  endtask

  int wd_done_cyc, wd_terr, wd_grants;

  initial begin
    rstn = 1'b0; start = 1'b0; start_wd = 1'b0; cfg_per_channel = 1'b0;
    n_ch = 0; n_rows = 0; load_quant_req = 1'b0; quant_params_valid = 1'b0;
    bus_busy = 1'b0; out_valid = 1'b0; cyc = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {init_cfg, load_quant_granted, tile_calc_start, busy, done, timeout_err}, 0);
    chk("rst_base", tile_ch_base, 0);
    chk("rst_cnt", tile_ch_cnt, 0);
    rstn = 1'b1;

    // Per-tensor, single group
    run_job(1'b0, 16, 4, 0);
    chk("pt_tcs_cycle", tcs1_cyc, 2);
    chk("pt_done_cycle", done_cyc, 8);
    chk("pt_no_grant", n_grant, 0);

    // Per-channel, three groups with a partial tail
    run_job(1'b1, 40, 2, 0);
    chk("pc_grants", n_grant, 3);
    chk("pc_group_starts", n_tcs, 3);

    // Grant withheld while the bus is owned elsewhere
    run_job(1'b1, 16, 1, 1);
    chk("busy_grant_count", n_grant, 1);

    // Empty job and a stray start during compute
    run_job(1'b0, 16, 0, 0);
    chk("zero_rows_done_cycle", done_cyc, 2);
    chk("zero_rows_no_tcs", n_tcs, 0);
    run_job(1'b0, 16, 4, 2);
    chk("stray_start_done_cycle", done_cyc, 8);

    // Watchdog on the short-timeout instance; parameters never arrive
    wd_done_cyc = -1; wd_terr = -1; wd_grants = 0;
    @(posedge clk); #1;
    cyc = 0;
    cfg_per_channel = 1'b1; n_ch = 16; n_rows = 1;
    load_quant_req = 1'b1; quant_params_valid = 1'b0; bus_busy = 1'b0;
    start_wd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      monitor();
      if (grant_wd) wd_grants++;
      if (done_wd && wd_done_cyc < 0) begin
        wd_done_cyc = cyc;
        wd_terr     = int'(timeout_err_wd);
      end
      @(posedge clk); #1;
      cyc++;
      start_wd = 1'b0;
    end
    chk("wd_done_cycle", wd_done_cyc, 10);
    chk("wd_terr_at_done", wd_terr, 1);
    chk("wd_grant_once", wd_grants, 1);
    chk("wd_idle", busy_wd, 0);
    chk("wd_terr_sticky", timeout_err_wd, 1);

    // Next accepted start clears the sticky error
    quant_params_valid = 1'b1;
    out_valid          = 1'b1;
    start_wd           = 1'b1;
    @(posedge clk); #1;
    start_wd = 1'b0;
    @(negedge clk);
    chk("wd_terr_cleared", timeout_err_wd, 0);
    wd_done_cyc = -1;
    for (int i = 0; i < 50 && wd_done_cyc < 0; i++) begin
      @(negedge clk);
      if (done_wd) begin
        wd_done_cyc = i;
        chk("wd_second_terr", timeout_err_wd, 0);
      end
    end
    chk("wd_second_job_done", (wd_done_cyc >= 0), 1);
    out_valid = 1'b0;

    // Asynchronous reset in the middle of a compute phase
    @(posedge clk); #1;
    cfg_per_channel = 1'b0; n_ch = 32; n_rows = 8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("midjob_rst_ctrl", {init_cfg, load_quant_granted, tile_calc_start, busy, done, timeout_err}, 0);
    chk("midjob_rst_base", tile_ch_base, 0);
    chk("midjob_rst_cnt", tile_ch_cnt, 0);
    out_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    run_job(1'b1, 20, 3, 0);
    chk("post_reset_grants", n_grant, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/requant_tile_sched.md
REQUANT_TILE_SCHED -- requirements
Module: requant_tile_sched

Interface
REQ-001 SHALL have parameter VLEN, default 16, lanes per channel group.
REQ-002 SHALL have parameter REG_WIDTH, default 32, width of dimension and index fields.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, handshake watchdog limit in cycles.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle job start.
REQ-007 SHALL have port cfg_per_channel  in  1  1=per-channel, 0=per-tensor.
REQ-008 SHALL have port n_ch  in  REG_WIDTH  output channel count.
REQ-009 SHALL have port n_rows  in  REG_WIDTH  result vectors per channel group.
REQ-010 SHALL have port init_cfg  out  1  configuration pulse to the requant unit.
REQ-011 SHALL have port load_quant_req  in  1  parameter-fetch request from the requant unit.
REQ-012 SHALL have port load_quant_granted  out  1  one-cycle fetch grant.
REQ-013 SHALL have port quant_params_valid  in  1  parameters loaded.
REQ-014 SHALL have port bus_busy  in  1  shared ICB is owned by another master.
REQ-015 SHALL have port out_valid  in  1  requant output beat.
REQ-016 SHALL have port tile_calc_start  out  1  one-cycle group compute start.
REQ-017 SHALL have port tile_ch_base  out  REG_WIDTH  first channel of the current group.
REQ-018 SHALL have port tile_ch_cnt  out  $clog2(VLEN+1)  valid lanes in the current group.
REQ-019 SHALL have ports busy, done, timeout_err  out  1 each  busy level, completion pulse, sticky error.

Function
REQ-020 SHALL implement states IDLE, CFG, WAIT_REQ, GRANT, WAIT_PARAM, COMPUTE, NEXT.
REQ-021 SHALL, in IDLE, on start, latch cfg_per_channel, n_ch and n_rows, clear timeout_err, clear tile_ch_base, and enter CFG; start SHALL be ignored when not in IDLE.
REQ-022 SHALL assert init_cfg for exactly the single cycle spent in CFG (start at cycle 0, init_cfg at cycle 1).
REQ-023 SHALL, from CFG, go to IDLE with a done pulse when n_ch==0 or n_rows==0; otherwise go to WAIT_REQ if per-channel, else to COMPUTE.
REQ-024 SHALL, in WAIT_REQ, move to GRANT when load_quant_req=1.
REQ-025 SHALL, in GRANT, drive load_quant_granted=1 for one cycle only when load_quant_req=1 and bus_busy=0, then enter WAIT_PARAM; with bus_busy=1 it SHALL hold GRANT with the grant deasserted.
REQ-026 SHALL, in WAIT_PARAM, enter COMPUTE when quant_params_valid=1.
REQ-027 SHALL pulse tile_calc_start for one cycle on every entry into COMPUTE and clear the beat counter at the same time.
REQ-028 SHALL, in COMPUTE, count out_valid beats and, in the cycle the count reaches n_rows, enter NEXT; out_valid SHALL be ignored in all other states.
REQ-029 SHALL, in NEXT, go to IDLE with a done pulse when tile_ch_base+VLEN >= n_ch; otherwise add VLEN to tile_ch_base and go to WAIT_REQ (per-channel) or COMPUTE (per-tensor).
REQ-030 SHALL drive tile_ch_cnt = min(VLEN, n_ch - tile_ch_base) combinationally from registered values.
REQ-031 SHALL count consecutive cycles spent in WAIT_REQ, GRANT or WAIT_PARAM, and when the count reaches TIMEOUT_CYC SHALL set timeout_err, pulse done, and return to IDLE.
REQ-032 SHALL keep timeout_err set until the next accepted start.
REQ-033 SHALL drive busy=1 in every state except IDLE.
REQ-034 SHALL use REG_WIDTH+1-bit arithmetic for the tile_ch_base+VLEN comparison so that the comparison never wraps.

Reset
REQ-035 SHALL, on rstn=0, force state IDLE, and set all counters, tile_ch_base, init_cfg, load_quant_granted, tile_calc_start, busy, done and timeout_err to 0, including when reset is applied mid-job.

Verification
REQ-036 Per-tensor, n_ch=16, n_rows=4, 4 out_valid beats -> init_cfg at cycle 1, tile_calc_start at cycle 2, one done pulse, no grant.
REQ-037 Per-channel, n_ch=40, n_rows=2 -> three groups with tile_ch_base 0/16/32 and tile_ch_cnt 16/16/8, three grants, three tile_calc_start pulses, then done.
REQ-038 Per-channel, load_quant_req=1 while bus_busy=1 for 5 cycles -> grant withheld for those 5 cycles, then a single-cycle grant after bus_busy falls.
REQ-039 TIMEOUT_CYC=8, quant_params_valid never asserted -> timeout_err=1 and a done pulse after 8 waiting cycles; the next start clears timeout_err.
REQ-040 n_rows=0 -> done at cycle 2 with no tile_calc_start; a start pulse during COMPUTE is ignored.
REQ-041 rstn asserted during COMPUTE -> all outputs read 0 and state is IDLE immediately, and a subsequent job runs normally.
